usr_ctrl: RTL and testbench
===========================

# usr_ctrl

Command sequencer that drives the universal shift register (USR) datapath. Accepts one operation at a time over a valid/ready handshake: parallel load, logical shift right, logical shift left, or rotate right by a programmable count. It generates the USR `sel`, `PI` and `SI` inputs cycle by cycle and monitors `PO` for rotate feedback. It signals completion with a one-cycle `done` pulse. It sits directly upstream of USR and shares its clock.

## Interface
- `W`, 5, data width; must match USR width.
- `CW`, 3, width of shift count; max count is 2^CW-1.

- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `cmd_valid`  in  1  command present.
- `cmd_ready`  out  1  controller can accept a command; high only in IDLE.
- `cmd_op`  in  2  operation: 00 LOAD, 01 SHR, 10 SHL, 11 ROR.
- `cmd_data`  in  W  parallel load value; used by LOAD only.
- `cmd_count`  in  CW  number of shift steps; ignored by LOAD.
- `cmd_si`  in  1  fill bit for SHR/SHL; ignored by LOAD/ROR.
- `PO`  in  W  USR parallel output; used for ROR feedback.
- `sel`  out  2  USR mode: 00 hold, 01 shift right, 10 shift left, 11 parallel load.
- `PI`  out  W  USR parallel input.
- `SI`  out  1  USR serial input.
- `busy`  out  1  high from the cycle after acceptance until the `done` cycle, inclusive.
- `done`  out  1  one-cycle completion pulse.

## Operation
USR semantics driven by this block:
- Shift right: PO ← {SI, PO[W-1:1]}.
- Shift left: PO ← {PO[W-2:0], SI}.
- Load: PO ← PI.

State machine: IDLE, LOAD, SHIFT, DONE.
- IDLE
  - `cmd_ready`=1, `sel`=00.
  - On `cmd_valid`&&`cmd_ready`, register op, data, count and si.
  - LOAD → LOAD; SHR/SHL/ROR with count>0 → SHIFT; count==0 → DONE.
- LOAD
  - One cycle: `sel`=11, `PI`=registered data.
  - → DONE.
- SHIFT
  - `sel`=01 (SHR/ROR) or 10 (SHL).
  - `SI` = registered si for SHR/SHL; for ROR, `SI` = `PO[0]` (combinational from the current PO).
  - Remaining-count register decrements each cycle; at count 1 → DONE.
- DONE
  - `sel`=00, `done`=1 for exactly one cycle.
  - → IDLE.

General rules:
- Outside LOAD, `PI` holds its last value.
- Outside SHIFT, `SI`=0.
- `cmd_valid` while not ready is ignored. It is not queued; the source must hold it.
- Count arithmetic is unsigned CW-bit. The decrement never wraps, because the exit occurs at 1.

Reset (any time, including mid-SHIFT):
- Immediately forces IDLE: `sel`=00, `PI`=0, `SI`=0, `busy`=0, `done`=0, `cmd_ready`=1 after deassertion.
- Partial shifts already applied to USR are not undone; USR contents are the USR's own reset responsibility.

## Timing
- Command accepted at rising edge k (valid&&ready sampled).
- LOAD:
  - `sel`=11 during cycle k+1.
  - USR captures at edge k+2.
  - `done` high during cycle k+2; `cmd_ready` high again in cycle k+3.
- Shift by N≥1:
  - Shift `sel` asserted during cycles k+1..k+N, so USR performs exactly N shifts.
  - `done` high during cycle k+N+1.
- Shift by N=0: `done` high in cycle k+1, with `sel`=00 throughout.
- Back-to-back commands: minimum spacing between acceptances is latency+1 cycles. No command is accepted in the `done` cycle.
- All outputs are registered or decoded from state, except ROR `SI`, which has a combinational path from `PO`.

## Test plan
- Reset and LOAD:
  - Assert `rst`=0, then release.
  - Check `sel`=00, `PI`=0, `SI`=0, `cmd_ready`=1.
  - Send LOAD with data=10101: `sel`=11 for one cycle, PO=10101, `done` pulses once.
- SHR with fill 1:
  - From PO=10101, send SHR count=2 si=1.
  - `sel`=01 for exactly 2 cycles; PO sequence 11010, 11101; `done` in cycle k+3.
- SHL with fill 0:
  - From 10101, send SHL count=3 si=0.
  - PO sequence 01010, 10100, 01000; `busy` high for 4 cycles.
- ROR:
  - From 10101, ROR count=1 gives 11010.
  - Then ROR count=5 returns PO to 11010 unchanged.
  - `SI` equals `PO[0]` in every shift cycle.
- Count 0 and handshake:
  - SHR count=0: `done` one cycle after acceptance, PO unchanged.
  - `cmd_valid` held during `busy`: no second acceptance until `cmd_ready`=1.
- Reset mid-operation:
  - Start SHL count=7; assert `rst`=0 after 3 shift cycles.
  - `sel`=00 and `busy`=0 asynchronously; no `done` pulse.
  - The next command after release executes normally.

Source files
------------

// File: rtl/usr_ctrl.sv
// Command sequencer for the universal shift register: turns LOAD/SHR/SHL/ROR commands
// into cycle-by-cycle sel/PI/SI drive and pulses done when finished.
module usr_ctrl #(
  parameter int W  = 5,
  parameter int CW = 3
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic [1:0]    cmd_op,
  input  logic [W-1:0]  cmd_data,
  input  logic [CW-1:0] cmd_count,
  input  logic          cmd_si,
  input  logic [W-1:0]  PO,
  output logic [1:0]    sel,
  output logic [W-1:0]  PI,
  output logic          SI,
  output logic          busy,
  output logic          done
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_LOAD  = 2'd1;
  localparam logic [1:0] S_SHIFT = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  localparam logic [1:0] OP_LOAD = 2'b00;
  localparam logic [1:0] OP_SHR  = 2'b01;
  localparam logic [1:0] OP_SHL  = 2'b10;
  localparam logic [1:0] OP_ROR  = 2'b11;

  localparam logic [1:0] SEL_HOLD = 2'b00;
  localparam logic [1:0] SEL_SHR  = 2'b01;
  localparam logic [1:0] SEL_SHL  = 2'b10;
  localparam logic [1:0] SEL_LOAD = 2'b11;

  logic [1:0]    state;
  logic [1:0]    op_r;
  logic [CW-1:0] cnt_r;
  logic          si_r;
  logic [W-1:0]  data_r;

  // Only PO[0] is needed (rotate feedback); the upper bits are deliberately ignored.
  logic unused_po;
  assign unused_po = ^PO[W-1:1];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= S_IDLE;
      op_r   <= OP_LOAD;
      cnt_r  <= '0;
      si_r   <= 1'b0;
      data_r <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (cmd_valid) begin
            op_r  <= cmd_op;
            cnt_r <= cmd_count;
            si_r  <= cmd_si;
            if (cmd_op == OP_LOAD) begin
              data_r <= cmd_data;
              state  <= S_LOAD;
            end else if (cmd_count == '0) begin
              state <= S_DONE;
            end else begin
              state <= S_SHIFT;
            end
          end
        end
        S_LOAD: state <= S_DONE;
        S_SHIFT: begin
          // Exit on the last step so the count never wraps below one.
          if (cnt_r == CW'(1)) begin
            state <= S_DONE;
          end else begin
            cnt_r <= cnt_r - CW'(1);
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // PI is the data register itself, so it holds its last load value outside LOAD.
  assign PI        = data_r;
  assign cmd_ready = (state == S_IDLE);
  assign busy      = (state != S_IDLE);
  assign done      = (state == S_DONE);

  always_comb begin
    sel = SEL_HOLD;
    SI  = 1'b0;
    case (state)
      S_LOAD: sel = SEL_LOAD;
      S_SHIFT: begin
        sel = (op_r == OP_SHL) ? SEL_SHL : SEL_SHR;
        SI  = (op_r == OP_ROR) ? PO[0] : si_r;
      end
      default: begin
        sel = SEL_HOLD;
        SI  = 1'b0;
      end
    endcase
  end

  logic unused_op;
  assign unused_op = (OP_SHR == OP_SHR);

endmodule

// File: tb/tb_usr_ctrl.sv
// Directed bench for usr_ctrl driving a behavioural USR model; expected values are hand-computed.
module tb_usr_ctrl;

  localparam int W  = 5;
  localparam int CW = 3;

  logic          clk = 1'b0;
  logic          rst;
  logic          cmd_valid;
  logic          cmd_ready;
  logic [1:0]    cmd_op;
  logic [W-1:0]  cmd_data;
  logic [CW-1:0] cmd_count;
  logic          cmd_si;
  logic [W-1:0]  PO = '0;
  logic [1:0]    sel;
  logic [W-1:0]  PI;
  logic          SI;
  logic          busy;
  logic          done;

  usr_ctrl #(.W(W), .CW(CW)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_data(cmd_data), .cmd_count(cmd_count), .cmd_si(cmd_si),
    .PO(PO), .sel(sel), .PI(PI), .SI(SI), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  // USR model; it has no reset of its own, so partial shifts survive a controller reset.
  always @(posedge clk) begin
    case (sel)
      2'b01: PO <= {SI, PO[W-1:1]};
      2'b10: PO <= {PO[W-2:0], SI};
      2'b11: PO <= PI;
      default: PO <= PO;
    endcase
  end

  int acc_cnt = 0;
  always @(posedge clk) if (cmd_valid && cmd_ready) acc_cnt <= acc_cnt + 1;

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  logic [W-1:0] po_seq  [0:31];
  logic [1:0]   sel_seq [0:31];
  int n_act, done_at, n_done, n_busy, si_bad, last_i;

  // Issue one command from IDLE and observe every cycle until cmd_ready returns.
  task automatic run_cmd(input logic [1:0] op, input logic [W-1:0] data,
                         input logic [CW-1:0] cnt, input logic s);
    n_act = 0; done_at = 0; n_done = 0; n_busy = 0; si_bad = 0; last_i = 0;
    @(negedge clk);
    chk("ready_before_cmd", cmd_ready, 1);
    cmd_valid = 1'b1; cmd_op = op; cmd_data = data; cmd_count = cnt; cmd_si = s;
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    po_seq[0] = PO;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      po_seq[i]  = PO;
      sel_seq[i] = sel;
      last_i     = i;
      if (sel != 2'b00) n_act++;
      if (busy) n_busy++;
      if (done) begin
        n_done++;
        if (done_at == 0) done_at = i;
      end
      if (sel == 2'b01 || sel == 2'b10) begin
        if (SI !== ((op == 2'b11) ? PO[0] : s)) si_bad++;
      end else if (SI !== 1'b0) begin
        si_bad++;
      end
      if (cmd_ready) break;
    end
  endtask

  int acc0;
  int rst_done;

  initial begin
    rst = 1'b0;
    cmd_valid = 1'b0; cmd_op = 2'b00; cmd_data = '0; cmd_count = '0; cmd_si = 1'b0;
    #23 rst = 1'b1;
    @(negedge clk);
    chk("rst_sel", sel, 0);
    chk("rst_pi", PI, 0);
    chk("rst_si", SI, 0);
    chk("rst_ready", cmd_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);

    run_cmd(2'b00, 5'b10101, 3'd0, 1'b0);
    chk("load_sel", sel_seq[1], 2'b11);
    chk("load_nact", n_act, 1);
    chk("load_done_at", done_at, 2);
    chk("load_ndone", n_done, 1);
    chk("load_po", po_seq[2], 5'b10101);
    chk("load_ready_at", last_i, 3);
    chk("load_pi_hold", PI, 5'b10101);

    run_cmd(2'b01, 5'b00000, 3'd2, 1'b1);
    chk("shr_sel", sel_seq[1], 2'b01);
    chk("shr_nact", n_act, 2);
    chk("shr_po1", po_seq[2], 5'b11010);
    chk("shr_po2", po_seq[3], 5'b11101);
    chk("shr_done_at", done_at, 3);
    chk("shr_si", si_bad, 0);
    chk("shr_pi_hold", PI, 5'b10101);

    run_cmd(2'b00, 5'b10101, 3'd0, 1'b0);
    run_cmd(2'b10, 5'b00000, 3'd3, 1'b0);
    chk("shl_sel", sel_seq[1], 2'b10);
    chk("shl_po1", po_seq[2], 5'b01010);
    chk("shl_po2", po_seq[3], 5'b10100);
    chk("shl_po3", po_seq[4], 5'b01000);
    chk("shl_busy", n_busy, 4);
    chk("shl_done_at", done_at, 4);

    run_cmd(2'b00, 5'b10101, 3'd0, 1'b0);
    run_cmd(2'b11, 5'b00000, 3'd1, 1'b0);
    chk("ror1_po", po_seq[last_i], 5'b11010);
    chk("ror1_si", si_bad, 0);
    chk("ror1_done_at", done_at, 2);
    run_cmd(2'b11, 5'b00000, 3'd5, 1'b1);
    chk("ror5_po", po_seq[last_i], 5'b11010);
    chk("ror5_nact", n_act, 5);
    chk("ror5_si", si_bad, 0);
    chk("ror5_done_at", done_at, 6);

    run_cmd(2'b01, 5'b00000, 3'd0, 1'b1);
    chk("cnt0_done_at", done_at, 1);
    chk("cnt0_nact", n_act, 0);
    chk("cnt0_po", po_seq[last_i], 5'b11010);
    chk("cnt0_busy", n_busy, 1);

    // cmd_valid held across busy: a second acceptance only once cmd_ready returns.
    acc0 = acc_cnt;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_op = 2'b00; cmd_data = 5'b11010; cmd_count = '0; cmd_si = 1'b0;
    @(negedge clk);
    chk("hs_ready_k1", cmd_ready, 0);
    @(negedge clk);
    chk("hs_ready_k2", cmd_ready, 0);
    chk("hs_acc_k2", acc_cnt - acc0, 1);
    @(negedge clk);
    chk("hs_ready_k3", cmd_ready, 1);
    chk("hs_acc_k3", acc_cnt - acc0, 1);
    @(negedge clk);
    cmd_valid = 1'b0;
    chk("hs_acc_k4", acc_cnt - acc0, 2);
    chk("hs_busy_k4", busy, 1);
    repeat (3) @(negedge clk);
    chk("hs_idle", cmd_ready, 1);

    // Reset after three SHL shifts of 11010: 10100, 01000, 10000 remain in the USR.
    @(negedge clk);
    cmd_valid = 1'b1; cmd_op = 2'b10; cmd_data = '0; cmd_count = 3'd7; cmd_si = 1'b0;
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    repeat (3) @(negedge clk);
    @(posedge clk);
    #2 rst = 1'b0;
    #1;
    chk("mid_rst_sel", sel, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_si", SI, 0);
    chk("mid_rst_pi", PI, 0);
    rst_done = 0;
    repeat (2) begin
      @(negedge clk);
      if (done) rst_done++;
    end
    rst = 1'b1;
    repeat (4) begin
      @(negedge clk);
      if (done) rst_done++;
    end
    chk("mid_rst_nodone", rst_done, 0);
    chk("mid_rst_ready", cmd_ready, 1);
    chk("mid_rst_po", PO, 5'b10000);

    run_cmd(2'b00, 5'b01100, 3'd0, 1'b0);
    chk("post_rst_done_at", done_at, 2);
    chk("post_rst_po", po_seq[last_i], 5'b01100);
    run_cmd(2'b01, 5'b00000, 3'd1, 1'b0);
    chk("post_rst_shr", po_seq[last_i], 5'b00110);
    chk("post_rst_shr_done", done_at, 2);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: simulation did not reach the end, errors %0d", n_errors);
    $fatal(1);
  end

endmodule
